// File: rtl/hqm_rcfwl_pgcb_ctech_multisync_filter_pkg.sv
// PGCB multisync filter: shared limits and helpers.
// Imported by the channel and top-level modules.
package hqm_rcfwl_pgcb_sync_pkg;

    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 4;
    localparam int FILTER_MAX = 15;

    // Width of a counter that must hold 0..f-1; never narrower than 1.
    function automatic int cnt_width(input int f);
        return (f < 2) ? 1 : $clog2(f + 1);
    endfunction

endpackage

// File: rtl/hqm_rcfwl_pgcb_ctech_multisync_filter_if.sv
// PGCB multisync filter: channel bundle between async
// sources (master side) and the synchroniser bank (slave side).
interface hqm_rcfwl_pgcb_ctech_multisync_filter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] d;
    logic             hold;
    logic [WIDTH-1:0] chg_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] chg_sts;

    modport master (
        output d, hold, chg_clr,
        input  q, rise, fall, chg_sts
    );

    modport slave (
        input  d, hold, chg_clr,
        output q, rise, fall, chg_sts
    );
endinterface

// File: rtl/hqm_rcfwl_pgcb_ctech_multisync_filter_chan.sv
// PGCB multisync filter: one channel.
// Sync chain, glitch filter, edge pulses, sticky change bit.
module hqm_rcfwl_pgcb_sync_filter_chan
    import hqm_rcfwl_pgcb_sync_pkg::*;
#(
    parameter int   STAGES     = 2,
    parameter int   FILTER_CNT = 3,
    parameter logic RST_BIT    = 1'b0
) (
    input  logic clk,
    input  logic clr_b,
    input  logic d,
    input  logic hold,
    input  logic chg_clr,
    output logic q,
    output logic rise,
    output logic fall,
    output logic chg_sts
);

    // First flop stays separately named: it is the metastable one.
    logic              sync_meta;
    logic [STAGES-2:0] sync_pipe;
    logic              s;
    logic              q_r;
    logic              q_d;

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!clr_b) begin
            sync_meta <= RST_BIT;
            sync_pipe <= {(STAGES-1){RST_BIT}};
        end else begin
            sync_meta <= d;
            sync_pipe <= (STAGES-1)'({sync_pipe, sync_meta});
        end
    end

    assign s = sync_pipe[STAGES-2];

    if (FILTER_CNT == 0) begin : g_byp
        // No filtering: q follows the synced level unless held.
        always_ff @(posedge clk) begin
            if (!clr_b) begin
                q_r <= RST_BIT;
            end else if (!hold) begin
                q_r <= s;
            end
        end
    end else begin : g_flt
        localparam int CW = cnt_width(FILTER_CNT);
        localparam logic [CW-1:0] LAST = CW'(FILTER_CNT - 1);

        logic [CW-1:0] cnt;

        // Count consecutive differing samples; commit on the last one.
        always_ff @(posedge clk) begin
            if (!clr_b) begin
                cnt <= '0;
                q_r <= RST_BIT;
            end else if (!hold) begin
                if (s == q_r) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    q_r <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // Delayed copy of q for edge detection; runs even during hold.
    always_ff @(posedge clk) begin
        if (!clr_b) begin
            q_d <= RST_BIT;
        end else begin
            q_d <= q_r;
        end
    end

    assign q    = q_r;
    assign rise = q_r & ~q_d;
    assign fall = ~q_r & q_d;

    // Sticky change flag; a new edge beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!clr_b) begin
            chg_sts <= 1'b0;
        end else if (rise | fall) begin
            chg_sts <= 1'b1;
        end else if (chg_clr) begin
            chg_sts <= 1'b0;
        end
    end

endmodule

// File: rtl/hqm_rcfwl_pgcb_ctech_multisync_filter.sv
// PGCB multisync filter: bank of independent single-bit
// synchroniser/filter channels with parameter range checks.
module hqm_rcfwl_pgcb_ctech_multisync_filter
    import hqm_rcfwl_pgcb_sync_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 2,
    parameter int               FILTER_CNT = 3,
    parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
    input logic clk,
    input logic clr_b,
    hqm_rcfwl_pgcb_ctech_multisync_filter_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH must be 1..32");
    end

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("STAGES must be 2..4");
    end

    if (FILTER_CNT < 0 || FILTER_CNT > FILTER_MAX) begin : g_bad_filter
        $error("FILTER_CNT must be 0..15");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        hqm_rcfwl_pgcb_sync_filter_chan #(
            .STAGES     (STAGES),
            .FILTER_CNT (FILTER_CNT),
            .RST_BIT    (RST_VAL[i])
        ) u_chan (
            .clk     (clk),
            .clr_b   (clr_b),
            .d       (bus.d[i]),
            .hold    (bus.hold),
            .chg_clr (bus.chg_clr[i]),
            .q       (bus.q[i]),
            .rise    (bus.rise[i]),
            .fall    (bus.fall[i]),
            .chg_sts (bus.chg_sts[i])
        );
    end

endmodule
